cell_truth_prober: RTL and testbench
====================================

// Module: cell_truth_prober
// PURPOSE
//  Sequential checker for one discrete-transistor logic cell on the RV523 bring-up fixture.
//  Drives every input vector of the cell under test (default NAND2, 2 inputs), waits for the
//  transistors to settle, then samples the cell's Y pin and compares it against a truth table.
//  Reports pass/fail, an error count and the first failing vector; the fixture CPU polls it.
// PARAMETERS
//  N_IN    2         number of cell inputs driven (1..4)
//  SETTLE  8         cycles each vector is held before sampling (>=3; covers 2-flop sync)
//  EXPECT  4'b0111   expected Y per vector; bit i = Y for drive==i (2**N_IN bits; NAND2 default)
// PORTS
//  clk       in   1        fixture clock, rising edge
//  rst       in   1        asynchronous reset, active-high
//  start     in   1        1-cycle request to run a full sweep; sampled only in IDLE
//  abort     in   1        stop the sweep, go to IDLE, done not pulsed
//  sense     in   1        cell Y pin, asynchronous to clk
//  drive     out  N_IN     cell input pins A1..A<N_IN> (bit0 = A1)
//  busy      out  1        high from cycle after accepted start until done pulse
//  done      out  1        1-cycle pulse when a sweep completes
//  pass      out  1        1 iff last completed sweep had zero mismatches; held until next start
//  err_count out  N_IN+1   mismatches in current/last sweep, saturating at all-ones
//  fail_vec  out  N_IN     first mismatching vector (0 if none)
//  fail_got  out  1        Y value sampled at fail_vec
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, sync flops 0, counters 0. Reset mid-sweep drops drive to 0
//  immediately (asynchronously); no done pulse.
//  sense passes through a 2-flop synchronizer; comparisons use the synchronized value only.
//  FSM IDLE -> DRIVE -> SAMPLE -> (DRIVE | DONE) -> IDLE:
//   IDLE:   drive=0. start=1 -> clear err_count/fail_vec/fail_got/pass, vec=0, busy=1, DRIVE.
//   DRIVE:  drive=vec; settle counter runs SETTLE cycles, then SAMPLE.
//   SAMPLE: drive=vec held; if sense_sync != EXPECT[vec]: err_count++ (saturate); if this is the
//           first mismatch latch fail_vec=vec, fail_got=sense_sync. vec==2**N_IN-1 -> DONE,
//           else vec++ and DRIVE.
//   DONE:   drive=0, done=1 for exactly one cycle, pass=(err_count==0), busy=0, -> IDLE.
//  Timing: start at edge t -> drive=0 vector from t+1; each vector occupies SETTLE+1 cycles;
//  done high in cycle t+1+2**N_IN*(SETTLE+1).
//  start while busy is ignored (no restart, no queueing). abort has priority over start and
//  over all state transitions: next cycle IDLE, drive=0, busy=0, counters keep partial values,
//  pass=0. start and abort in the same IDLE cycle -> abort wins, no sweep.
//  Vector counter is N_IN+1 bits internally so last-vector detection never wraps.
//  Only one vector bit set changes per transition? No: binary order 0,1,2,3 is required.
// STRUCTURE
//  Shared package rv523_fixture_pkg: state enum {IDLE,DRIVE,SAMPLE,DONE}, NAND2/NOR2/INV truth
//  table constants, clog2-style width helper for the settle counter.
//  One sub-module: sync2 (generic 2-flop synchronizer, async active-high reset to 0) for sense.
//  Remainder (FSM, settle counter, vector counter, result registers) stays flat in this module.
// TESTING
//  1 Ideal NAND2 model (Y=~&drive, 2-cycle delay), start pulse -> done at t+1+4*9=t+37,
//    pass=1, err_count=0, drive sequence 0,1,2,3 each held 9 cycles, then 0.
//  2 Model with Y stuck at 1 -> pass=0, err_count=1, fail_vec=3, fail_got=1.
//  3 Model as NOR2 (EXPECT default) -> err_count=2, fail_vec=1, fail_got=0, pass=0.
//  4 start re-pulsed at cycles t+5 and t+20 -> ignored; single done at t+37, busy stays 1.
//  5 abort at t+12 -> next cycle IDLE, drive=0, busy=0, no done; new start runs full sweep.
//  6 rst asserted mid-SAMPLE (async, between edges) -> drive/busy/err_count 0 same instant;
//    after release a start gives a normal sweep with correct results.

Source files
------------

// File: rtl/rv523_fixture_pkg.sv
// Shared definitions for the RV523 bring-up fixture checkers.
//   state_t    : sweep FSM states
//   TT_*       : expected-Y truth tables, bit i = Y when the cell inputs equal i
//   cnt_width  : register width able to hold 0..n-1 (never below 1)
package rv523_fixture_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [1:0] TT_INV   = 2'b01;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cell_truth_prober_if.sv
// Fixture-side bus of the cell truth prober.
//   start/abort : sweep control from the fixture CPU
//   sense       : cell Y pin (asynchronous)
//   drive       : cell input pins, bit0 = A1
//   busy/done/pass/err_count/fail_vec/fail_got : sweep status and results
// master = fixture / cell side, slave = prober.
interface cell_truth_prober_if #(parameter int N_IN = 2);
  logic            start;
  logic            abort;
  logic            sense;
  logic [N_IN-1:0] drive;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] fail_vec;
  logic            fail_got;

  modport master (
    output start, abort, sense,
    input  drive, busy, done, pass, err_count, fail_vec, fail_got
  );

  modport slave (
    input  start, abort, sense,
    output drive, busy, done, pass, err_count, fail_vec, fail_got
  );
endinterface

// File: rtl/cell_truth_prober_sync2.sv
// Generic 2-flop synchronizer.
//   clk : destination clock     rst : async active-high reset, clears both stages
//   d   : asynchronous input    q   : synchronized output (2 cycles latency)
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cell_truth_prober.sv
// Sequential truth-table checker for one discrete-transistor logic cell.
// Walks drive through 0..2**N_IN-1 in binary order, holds each vector SETTLE
// cycles, samples the synchronized Y pin for one cycle and compares it with
// EXPECT. Reports pass, a saturating mismatch count and the first failing
// vector with the Y value seen there.
//   clk, rst : fixture clock, async active-high reset
//   bus      : cell_truth_prober_if.slave (start/abort/sense in, drive and results out)
module cell_truth_prober
  import rv523_fixture_pkg::*;
#(
  parameter int                    N_IN   = 2,
  parameter int                    SETTLE = 8,
  parameter logic [(2**N_IN)-1:0]  EXPECT = TT_NAND2
) (
  input  logic               clk,
  input  logic               rst,
  cell_truth_prober_if.slave bus
);

  localparam int NV = 2**N_IN;
  localparam int CW = cnt_width(SETTLE);

  state_t          state;
  logic [N_IN:0]   vec;        // one spare bit so the last-vector test never wraps
  logic [CW-1:0]   cnt;
  logic [N_IN-1:0] drive_q;
  logic            busy_q, done_q, pass_q, fail_got_q;
  logic [N_IN:0]   err_q;
  logic [N_IN-1:0] fail_vec_q;

  logic            sense_sync;

  sync2 #(.W(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.sense),
    .q   (sense_sync)
  );

  logic          mismatch, last_vec, settled;
  logic [N_IN:0] vec_inc, err_next;

  always_comb begin
    mismatch = (sense_sync != EXPECT[vec[N_IN-1:0]]);
    last_vec = (vec == (N_IN+1)'(NV-1));
    settled  = (cnt == CW'(SETTLE-1));
    vec_inc  = vec + (N_IN+1)'(1);
    err_next = err_q;
    if (mismatch && (err_q != '1))
      err_next = err_q + (N_IN+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      cnt        <= '0;
      drive_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_vec_q <= '0;
      fail_got_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        // Partial results stay visible; only the sweep itself is dropped.
        state   <= IDLE;
        drive_q <= '0;
        busy_q  <= 1'b0;
        pass_q  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            drive_q <= '0;
            if (bus.start) begin
              err_q      <= '0;
              fail_vec_q <= '0;
              fail_got_q <= 1'b0;
              pass_q     <= 1'b0;
              vec        <= '0;
              cnt        <= '0;
              busy_q     <= 1'b1;
              state      <= DRIVE;
            end
          end
          DRIVE: begin
            if (settled) begin
              cnt   <= '0;
              state <= SAMPLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          SAMPLE: begin
            err_q <= err_next;
            if (mismatch && (err_q == '0)) begin
              fail_vec_q <= vec[N_IN-1:0];
              fail_got_q <= sense_sync;
            end
            if (last_vec) begin
              drive_q <= '0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              pass_q  <= (err_next == '0);
              state   <= DONE;
            end else begin
              vec     <= vec_inc;
              drive_q <= vec_inc[N_IN-1:0];
              state   <= DRIVE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.drive     = drive_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_vec_q;
  assign bus.fail_got  = fail_got_q;

endmodule

// File: tb/tb_cell_truth_prober.sv
// Bench for cell_truth_prober: a behavioural cell (truth table + 2-cycle
// delay) drives sense; expected sweep results are derived from the table.
module tb_cell_truth_prober;
  import rv523_fixture_pkg::*;

  localparam int N_IN   = 2;
  localparam int SETTLE = 8;
  localparam logic [3:0] EXP = TT_NAND2;
  localparam int VC     = SETTLE + 1;
  localparam int SWEEP  = 4 * VC;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cell_truth_prober_if #(.N_IN(N_IN)) bus();

  cell_truth_prober #(.N_IN(N_IN), .SETTLE(SETTLE), .EXPECT(EXP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Cell under test: Y = cell_tt[inputs], 2 clock delay through the transistors.
  logic [3:0] cell_tt = 4'b0111;
  logic [1:0] d1 = 2'd0, d2 = 2'd0;
  always @(posedge clk) begin
    d1 <= bus.drive;
    d2 <= d1;
  end
  assign bus.sense = cell_tt[d2];

  function automatic int ref_errs(input logic [3:0] tt);
    int n = 0;
    for (int i = 0; i < 4; i++) if (tt[i] != EXP[i]) n++;
    return n;
  endfunction

  function automatic int ref_fvec(input logic [3:0] tt);
    for (int i = 0; i < 4; i++) if (tt[i] != EXP[i]) return i;
    return 0;
  endfunction

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.abort = 1'b0;
    #12;
    checks++;
    if ({bus.drive, bus.busy, bus.done, bus.pass, bus.err_count, bus.fail_vec, bus.fail_got} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got drive=%0d busy=%0b done=%0b pass=%0b err=%0d fvec=%0d fgot=%0b exp all 0",
               bus.drive, bus.busy, bus.done, bus.pass, bus.err_count, bus.fail_vec, bus.fail_got);
    end
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.drive !== 2'd0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%0b drive=%0d exp 0 0", bus.busy, bus.drive);
    end
  endtask

  // Full sweep against cell table tt; optional start re-pulses at t+5, t+20.
  task automatic test_sweep(input logic [3:0] tt, input string tag, input bit restart);
    int dones, first_done, e;
    logic [1:0] exp_drv;
    cell_tt = tt;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    dones = 0; first_done = -1;
    for (int j = 0; j < SWEEP + 8; j++) begin
      exp_drv = (j < SWEEP) ? 2'(j / VC) : 2'd0;
      checks++;
      if (bus.drive !== exp_drv) begin
        errors++;
        $display("FAIL %s drive j=%0d got %0d exp %0d", tag, j, bus.drive, exp_drv);
      end
      checks++;
      if (bus.busy !== (j < SWEEP)) begin
        errors++;
        $display("FAIL %s busy j=%0d got %0b exp %0b", tag, j, bus.busy, (j < SWEEP));
      end
      if (bus.done === 1'b1) begin
        dones++;
        if (first_done < 0) first_done = j;
      end
      bus.start = restart && (j == 4 || j == 19);
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++;
    if (dones != 1 || first_done != SWEEP) begin
      errors++;
      $display("FAIL %s done_timing got %0d pulses first at %0d exp 1 at %0d", tag, dones, first_done, SWEEP);
    end
    e = ref_errs(tt);
    checks++;
    if (bus.err_count !== 3'(e)) begin
      errors++;
      $display("FAIL %s err_count got %0d exp %0d", tag, bus.err_count, e);
    end
    checks++;
    if (bus.pass !== (e == 0)) begin
      errors++;
      $display("FAIL %s pass got %0b exp %0b", tag, bus.pass, (e == 0));
    end
    checks++;
    if (bus.fail_vec !== 2'(ref_fvec(tt))) begin
      errors++;
      $display("FAIL %s fail_vec got %0d exp %0d", tag, bus.fail_vec, ref_fvec(tt));
    end
    checks++;
    if (bus.fail_got !== ((e > 0) ? tt[ref_fvec(tt)] : 1'b0)) begin
      errors++;
      $display("FAIL %s fail_got got %0b exp %0b", tag, bus.fail_got, (e > 0) ? tt[ref_fvec(tt)] : 1'b0);
    end
  endtask

  task automatic test_nand();    test_sweep(4'b0111, "nand2", 1'b0); endtask
  task automatic test_stuck1();  test_sweep(4'b1111, "stuck1", 1'b0); endtask
  task automatic test_nor();     test_sweep(TT_NOR2, "nor2", 1'b0); endtask
  task automatic test_restart(); test_sweep(4'b0111, "restart_ignored", 1'b1); endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) test_sweep(4'($urandom), "random", 1'b0);
  endtask

  task automatic test_abort();
    int dones = 0;
    cell_tt = 4'b0000;            // vector 0 mismatches before the abort lands
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (11) @(negedge clk);
    bus.abort = 1'b1;
    bus.start = 1'b1;             // abort must win over a concurrent start
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.drive !== 2'd0 || bus.busy !== 1'b0 || bus.pass !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got drive=%0d busy=%0b pass=%0b exp 0 0 0", bus.drive, bus.busy, bus.pass);
    end
    checks++;
    if (bus.err_count !== 3'd1 || bus.fail_vec !== 2'd0) begin
      errors++;
      $display("FAIL abort_partial got err=%0d fvec=%0d exp 1 0", bus.err_count, bus.fail_vec);
    end
    for (int j = 0; j < SWEEP + 5; j++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d done/busy cycles exp 0", dones);
    end
    test_sweep(4'b0111, "after_abort", 1'b0);
  endtask

  task automatic test_async_reset();
    cell_tt = 4'b0000;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (17) @(negedge clk);  // vector 1 SAMPLE cycle
    checks++;
    if (bus.drive !== 2'd1 || bus.err_count !== 3'd1) begin
      errors++;
      $display("FAIL pre_reset got drive=%0d err=%0d exp 1 1", bus.drive, bus.err_count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.drive !== 2'd0 || bus.busy !== 1'b0 || bus.err_count !== 3'd0) begin
      errors++;
      $display("FAIL async_reset got drive=%0d busy=%0b err=%0d exp 0 0 0", bus.drive, bus.busy, bus.err_count);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done got %0b exp 0", bus.done);
    end
    test_sweep(TT_NOR2, "after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_nand();
    test_stuck1();
    test_nor();
    test_random();
    test_restart();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
